dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter that shares the single-port 256×32 data memory between requester 0 (CPU load/store stage) and requester 1 (DMA/debug loader). It grants one single-beat access per clock, drives the memory's write-enable, address and write-data, and returns registered read data to the winner one cycle later. It sits between the requesters and the data memory: combinational read, write on the rising edge, word index = address bits [7:0].

## Interface
- ADDR_W, 32: requester and memory address width.
- DATA_W, 32: data width.
- LOCK_MAX, 16: maximum consecutive locked grants before forced release. Range 2..255.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- mN_req  in  1  access request, N∈{0,1}; held with its qualifiers until granted.
- mN_we  in  1  1 = write, 0 = read.
- mN_addr  in  ADDR_W  word address (ALU result).
- mN_wdata  in  DATA_W  write data.
- mN_lock  in  1  request to keep ownership after this beat (used only with the lock feature).
- mN_gnt  out  1  access performed at this clock edge.
- mN_rvalid  out  1  one-cycle pulse; mN_rdata valid.
- mN_rdata  out  DATA_W  registered read data.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory combinational read data.

## Operation
- States: IDLE, OWN0, OWN1. IDLE is the only state without the lock feature.
- IDLE, single req: that requester wins. Both req: winner is the requester not in last_grant (round-robin); last_grant updates to the winner at each grant edge.
- OWNx: only x can be granted. The other requester stalls even if x has req=0.
- Winner's we/addr/wdata are muxed onto mem_*; mN_gnt = 1 for the winner only, combinational in the same cycle.
- No winner: mem_we = 0. mem_addr and mem_wdata follow m0 and are don't-care.
- Write grant: memory commits at the edge and no rvalid follows.
- Read grant: mem_rdata is captured into mN_rdata at the edge. mN_rvalid = 1 for the following cycle only. mN_rdata holds its value until the next read for that requester.
- Lock entry: from IDLE, a granted beat with mN_lock = 1 moves to OWNN and loads lock_cnt = 1.
- Lock continuation: each further granted beat in OWNN with lock = 1 increments lock_cnt.
- Lock exit to IDLE at the edge of any of:
  - owner granted with lock = 0 (that beat is still performed);
  - owner req = 0 for one cycle;
  - lock_cnt reaches LOCK_MAX on a granted beat (forced release).
- After any exit, last_grant = owner, so the other requester wins the next contention.
- Reset state: state IDLE; last_grant = 1 (m0 wins the first contention); lock_cnt = 0; m0/m1_rvalid = 0; m0/m1_rdata = 0.
- Reset outputs: mN_gnt = 0 and mem_we = 0 while reset is high.
- Reset mid-lock or mid-read: ownership is abandoned and pending rvalid is dropped.

## Timing
- Grant latency is 0 cycles when uncontested. Under continuous contention without lock, each requester waits at most 1 cycle.
- Read data latency is 1 cycle after the grant edge.
- Locked worst-case stall for the other requester is LOCK_MAX cycles, plus 1 cycle to win.
- Throughput is one access per cycle. Back-to-back grants to the same requester are allowed.
- Simultaneous events:
  - m0 write and m1 read to the same address in one cycle: only one is granted; the other sees the memory state after the first.
  - A read granted one cycle after a write to the same word returns the new data.

## Configuration
- DMEM_ARB_LOCK_EN defined: OWN0/OWN1 states, lock_cnt and LOCK_MAX forced release are compiled in.
- DMEM_ARB_LOCK_EN undefined:
  - mN_lock inputs exist but are ignored, and no lock state is built;
  - the FSM is IDLE only, giving pure round-robin;
  - LOCK_MAX is unused.

## Structure
- Package dmem_arb_pkg holds:
  - the state enum (IDLE, OWN0, OWN1);
  - requester id constants REQ_M0 = 0, REQ_M1 = 1;
  - the default LOCK_MAX.
- Sub-module dmem_rr_pick: combinational two-way round-robin pick, with inputs req[1:0], last_grant, owner_valid, owner and outputs gnt[1:0], winner. The FSM, counter, mux and read registers stay in dmem_arbiter.

## Test plan
- Reset with both req = 1 → no gnt and mem_we = 0 during reset. First edge after release grants m0; the next cycle grants m1.
- m0 writes 0xDEADBEEF to addr 0x05, next cycle m0 reads addr 0x05 → m0_rvalid pulses the cycle after the read grant with m0_rdata = 0xDEADBEEF. m1_rvalid stays 0.
- Both requesters read continuously (m0 addr 0x10, m1 addr 0x20) → gnt alternates m0, m1, m0, …; each rvalid follows its grant by exactly 1 cycle.
- LOCK_EN, m1 lock = 1 for 3 beats then lock = 0, with m0 requesting → m1 gets 4 consecutive grants and m0 is granted on the 5th cycle.
- LOCK_EN, LOCK_MAX = 16, m0 lock held at 1 while m1 requests → m0 is granted 16 beats, then forced release and m1 is granted in cycle 17.
- Assert reset while in OWN1 with a read grant just taken → m1_rvalid = 0 and state IDLE. After release, m0 wins contention.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// State encoding, requester ids and the default lock burst limit.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam logic REQ_M0 = 1'b0;
  localparam logic REQ_M1 = 1'b1;

  localparam int LOCK_MAX_DEF = 16;

endpackage

// File: rtl/dmem_rr_pick.sv
// Combinational two-way round-robin pick; a valid owner excludes the other requester.
// Zero latency; a stalled requester simply sees gnt low and holds its request.
module dmem_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       owner_valid,
  input  logic       owner,
  output logic [1:0] gnt,
  output logic       winner
);

  always_comb begin
    gnt    = 2'b00;
    winner = REQ_M0;
    if (owner_valid) begin
      winner = owner;
      if (req[owner]) gnt = owner ? 2'b10 : 2'b01;
    end else begin
      case (req)
        2'b01: begin
          winner = REQ_M0;
          gnt    = 2'b01;
        end
        2'b10: begin
          winner = REQ_M1;
          gnt    = 2'b10;
        end
        2'b11: begin
          // Contention goes to whoever did not win last.
          winner = ~last_grant;
          gnt    = last_grant ? 2'b01 : 2'b10;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the 256x32 data memory; one single-beat grant per clock, read data one cycle later.
// Grant is combinational (0 cycles); the loser holds its request until granted. Lock bursts need DMEM_ARB_LOCK_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = LOCK_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m0_lock,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic [1:0] req;
  logic [1:0] pick_gnt;
  logic [1:0] gnt;
  logic       winner;
  logic       last_grant;
  logic       owner_valid;
  logic       owner;

  assign req = {m1_req, m0_req};

  dmem_rr_pick u_pick (
    .req         (req),
    .last_grant  (last_grant),
    .owner_valid (owner_valid),
    .owner       (owner),
    .gnt         (pick_gnt),
    .winner      (winner)
  );

  // No grant may leak out while reset is asserted.
  assign gnt    = reset ? 2'b00 : pick_gnt;
  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];

  assign mem_we    = (gnt[0] & m0_we) | (gnt[1] & m1_we);
  assign mem_addr  = gnt[1] ? m1_addr  : m0_addr;
  assign mem_wdata = gnt[1] ? m1_wdata : m0_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      m0_rvalid <= gnt[0] & ~m0_we;
      m1_rvalid <= gnt[1] & ~m1_we;
      if (gnt[0] & ~m0_we) m0_rdata <= mem_rdata;
      if (gnt[1] & ~m1_we) m1_rdata <= mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= REQ_M1;
    end else if (|gnt) begin
      last_grant <= winner;
    end else if (owner_valid && !req[owner]) begin
      last_grant <= owner;
    end
  end

`ifdef DMEM_ARB_LOCK_EN
  localparam logic [7:0] LOCK_LAST = 8'(LOCK_MAX - 1);

  arb_state_e state;
  logic [7:0] lock_cnt;
  logic       win_lock;

  assign win_lock    = winner ? m1_lock : m0_lock;
  assign owner_valid = (state != IDLE);
  assign owner       = (state == OWN1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      lock_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if ((|gnt) && win_lock) begin
            state    <= winner ? OWN1 : OWN0;
            lock_cnt <= 8'd1;
          end
        end
        default: begin
          if (!req[owner]) begin
            state    <= IDLE;
            lock_cnt <= '0;
          end else if (|gnt) begin
            // Forced release keeps the other requester's stall bounded.
            if (!win_lock || lock_cnt == LOCK_LAST) begin
              state    <= IDLE;
              lock_cnt <= '0;
            end else begin
              lock_cnt <= lock_cnt + 8'd1;
            end
          end
        end
      endcase
    end
  end
`else
  logic unused_lock;

  assign owner_valid = 1'b0;
  assign owner       = REQ_M0;
  assign unused_lock = m0_lock ^ m1_lock ^ LOCK_MAX[0];
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed per-cycle vectors push expected grants and read returns.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [256];
  logic        mem_init;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  typedef struct {
    int         cyc;
    logic [1:0] g;
    logic       we;
    logic [7:0] addr;
  } gexp_t;

  typedef struct {
    int          cyc;
    logic        port;
    logic [31:0] data;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign mem_rdata = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
    end else if (mem_we) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
  end

  dmem_arbiter dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_lock   (m0_lock),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_lock   (m1_lock),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Monitor: pops an expectation whenever the DUT shows a grant or a read return.
  always @(negedge clk) begin
    if (m0_gnt || m1_gnt) begin
      tests++;
      if (gq.size() == 0) begin
        fails++;
        $display("FAIL gnt_unexpected cyc=%0d gnt=%b", cyc, {m1_gnt, m0_gnt});
      end else begin
        gexp_t e;
        e = gq.pop_front();
        if (e.cyc != cyc || {m1_gnt, m0_gnt} != e.g || mem_we != e.we || mem_addr[7:0] != e.addr) begin
          fails++;
          $display("FAIL gnt cyc=%0d gnt=%b we=%b addr=%h, expected cyc=%0d gnt=%b we=%b addr=%h",
                   cyc, {m1_gnt, m0_gnt}, mem_we, mem_addr[7:0], e.cyc, e.g, e.we, e.addr);
        end
      end
    end else if (!reset) begin
      tests++;
      if (mem_we !== 1'b0) begin
        fails++;
        $display("FAIL idle_mem_we cyc=%0d got %b expected 0", cyc, mem_we);
      end
    end
    if (m0_rvalid || m1_rvalid) begin
      tests++;
      if (rq.size() == 0 || (m0_rvalid && m1_rvalid)) begin
        fails++;
        $display("FAIL rvalid_unexpected cyc=%0d rvalid=%b", cyc, {m1_rvalid, m0_rvalid});
      end else begin
        rexp_t r;
        logic [31:0] d;
        r = rq.pop_front();
        d = m1_rvalid ? m1_rdata : m0_rdata;
        if (r.cyc != cyc || m1_rvalid != r.port || d != r.data) begin
          fails++;
          $display("FAIL rdata cyc=%0d port=%0d data=%h, expected cyc=%0d port=%0d data=%h",
                   cyc, m1_rvalid, d, r.cyc, r.port, r.data);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of requests and record what the DUT must do with them.
  task automatic step(input logic [1:0] req, input logic [1:0] we, input logic [1:0] lock,
                      input logic [7:0] a0, input logic [7:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1,
                      input logic [1:0] eg, input logic [31:0] erd, input bit drop_rd = 1'b0);
    gexp_t g;
    rexp_t r;
    m0_req = req[0]; m0_we = we[0]; m0_lock = lock[0]; m0_addr = {24'h0, a0}; m0_wdata = d0;
    m1_req = req[1]; m1_we = we[1]; m1_lock = lock[1]; m1_addr = {24'h0, a1}; m1_wdata = d1;
    if (eg != 2'b00) begin
      g.cyc  = cyc;
      g.g    = eg;
      g.we   = eg[1] ? we[1] : we[0];
      g.addr = eg[1] ? a1 : a0;
      gq.push_back(g);
      if (!g.we && !drop_rd) begin
        r.cyc  = cyc + 1;
        r.port = eg[1];
        r.data = erd;
        rq.push_back(r);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    mem_init = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = 32'h10; m0_wdata = '0;
    m1_req = 1'b1; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = 32'h20; m1_wdata = '0;
    @(posedge clk);
    #1 mem_init = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("reset_gnt", {30'h0, m1_gnt, m0_gnt}, 32'h0);
      chk("reset_mem_we", {31'h0, mem_we}, 32'h0);
      chk("reset_rvalid", {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
      chk("reset_rdata", m0_rdata | m1_rdata, 32'h0);
    end
    @(posedge clk);
    #1 reset = 1'b0;

    // Continuous contention: m0 first after reset, then strict alternation.
    step(2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 0, 0, 2'b01, 32'hA500_0010);
    step(2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 0, 0, 2'b10, 32'hA500_0020);
    step(2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 0, 0, 2'b01, 32'hA500_0010);
    step(2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 0, 0, 2'b10, 32'hA500_0020);

    // Write then read-back on m0.
    step(2'b01, 2'b01, 2'b00, 8'h05, 8'h20, 32'hDEAD_BEEF, 0, 2'b01, 0);
    step(2'b01, 2'b00, 2'b00, 8'h05, 8'h20, 0, 0, 2'b01, 32'hDEAD_BEEF);
    step(2'b00, 2'b00, 2'b00, 8'h05, 8'h20, 0, 0, 2'b00, 0);
    chk("m0_rdata_hold", m0_rdata, 32'hDEAD_BEEF);

    // Same-word write/read race: m1 reads the old word, then m0 writes, then m1 sees the new word.
    step(2'b11, 2'b01, 2'b00, 8'h30, 8'h30, 32'hCAFE_F00D, 0, 2'b10, 32'hA500_0030);
    step(2'b11, 2'b01, 2'b00, 8'h30, 8'h30, 32'hCAFE_F00D, 0, 2'b01, 0);
    step(2'b10, 2'b00, 2'b00, 8'h30, 8'h30, 0, 0, 2'b10, 32'hCAFE_F00D);

    step(2'b01, 2'b00, 2'b00, 8'h10, 8'h20, 0, 0, 2'b01, 32'hA500_0010);
`ifdef DMEM_ARB_LOCK_EN
    // m1 locks for three beats, releases on the fourth.
    repeat (3) step(2'b11, 2'b00, 2'b10, 8'h10, 8'h20, 0, 0, 2'b10, 32'hA500_0020);
    step(2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 0, 0, 2'b10, 32'hA500_0020);
    step(2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 0, 0, 2'b01, 32'hA500_0010);
    // m0 holds lock: 16 beats, then forced release to m1.
    step(2'b10, 2'b00, 2'b00, 8'h10, 8'h20, 0, 0, 2'b10, 32'hA500_0020);
    repeat (16) step(2'b11, 2'b00, 2'b01, 8'h10, 8'h20, 0, 0, 2'b01, 32'hA500_0010);
    step(2'b11, 2'b00, 2'b01, 8'h10, 8'h20, 0, 0, 2'b10, 32'hA500_0020);
    step(2'b00, 2'b00, 2'b00, 8'h10, 8'h20, 0, 0, 2'b00, 0);
    // Owner drops req: m1 stalls that cycle, lock ends, m1 then wins.
    step(2'b01, 2'b00, 2'b01, 8'h10, 8'h20, 0, 0, 2'b01, 32'hA500_0010);
    step(2'b10, 2'b00, 2'b00, 8'h10, 8'h20, 0, 0, 2'b00, 0);
    step(2'b10, 2'b00, 2'b00, 8'h10, 8'h20, 0, 0, 2'b10, 32'hA500_0020);
`else
    // Lock requests are ignored: contention keeps alternating.
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) step(2'b11, 2'b00, 2'b10, 8'h10, 8'h20, 0, 0, 2'b10, 32'hA500_0020);
      else            step(2'b11, 2'b00, 2'b10, 8'h10, 8'h20, 0, 0, 2'b01, 32'hA500_0010);
    end
`endif

    // Reset right after a locked m1 read grant: the pending rvalid must vanish.
    step(2'b10, 2'b00, 2'b10, 8'h10, 8'h20, 0, 0, 2'b10, 0, 1'b1);
    reset = 1'b1;
    #1;
    chk("midreset_m1_rvalid", {31'h0, m1_rvalid}, 32'h0);
    chk("midreset_m1_rdata", m1_rdata, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    step(2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 0, 0, 2'b01, 32'hA500_0010);
    step(2'b11, 2'b00, 2'b00, 8'h10, 8'h20, 0, 0, 2'b10, 32'hA500_0020);
    step(2'b00, 2'b00, 2'b00, 8'h10, 8'h20, 0, 0, 2'b00, 0);
    step(2'b00, 2'b00, 2'b00, 8'h10, 8'h20, 0, 0, 2'b00, 0);

    chk("gnt_queue_drained", 32'(gq.size()), 32'h0);
    chk("rd_queue_drained", 32'(rq.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
